// File: rtl/lvl_gen_pkg.sv
// Shared types and helpers for the pulse-to-level converter.
// Contents: state encoding, the state enum, and a counter width helper.
package lvl_gen_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_HOLD = 2'd1;
    localparam logic [1:0] ENC_GAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ENC_IDLE,
        HOLD = ENC_HOLD,
        GAP  = ENC_GAP
    } lvl_gen_state_t;

    // Bits needed to count 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lvl_gen_if.sv
// Event/level interface between a pulse producer, lvl_gen and its consumer.
// master: drives pulse_sig/ack, observes the level side.
// slave : lvl_gen itself; receives pulse_sig/ack, drives lvl_sig, pend_cnt, ovf, timeout.
interface lvl_gen_if #(
    parameter int unsigned PEND_W = 2
);
    logic              pulse_sig;
    logic              ack;
    logic              lvl_sig;
    logic [PEND_W-1:0] pend_cnt;
    logic              ovf;
    logic              timeout;

    modport master (
        output pulse_sig, ack,
        input  lvl_sig, pend_cnt, ovf, timeout
    );

    modport slave (
        input  pulse_sig, ack,
        output lvl_sig, pend_cnt, ovf, timeout
    );
endinterface

// File: rtl/lvl_gen_pend_ctr.sv
// pend_ctr: saturating up/down counter of queued events.
// Ports: clk, reset (async, active-high), inc, dec -> count, ovf (1-cycle drop pulse),
// nonzero (count != 0). All outputs registered.
module pend_ctr #(
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              ovf,
    output logic              nonzero
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] count_d, count_q;
    logic              ovf_d, ovf_q;
    logic              nonzero_d, nonzero_q;

    // Simultaneous inc/dec frees and refills one slot, so it never overflows.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (inc && !dec) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + PEND_W'(1);
            end
        end else if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - PEND_W'(1);
            end
        end
        nonzero_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            ovf_q     <= 1'b0;
            nonzero_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            nonzero_q <= nonzero_d;
        end
    end

    assign count   = count_q;
    assign ovf     = ovf_q;
    assign nonzero = nonzero_q;

endmodule

// File: rtl/lvl_gen.sv
// lvl_gen: converts single-cycle event pulses into acknowledged levels, queuing
// events that arrive while a level is active or cooling down.
// Ports: clk, reset (async, active-high), bus (lvl_gen_if.slave):
//   pulse_sig/ack in; lvl_sig, pend_cnt, ovf, timeout out (all registered).
// Build option: define LVL_GEN_TIMEOUT_EN to end a level after HOLD_CYCLES
// without ack; otherwise the hold counter is not built and timeout is tied low.
module lvl_gen
    import lvl_gen_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned PEND_W      = 2
) (
    input  logic       clk,
    input  logic       reset,
    lvl_gen_if.slave   bus
);
    localparam int unsigned      GAP_W    = cnt_width(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    lvl_gen_state_t    state_d, state_q;
    logic [GAP_W-1:0]  gap_cnt_d, gap_cnt_q;
    logic              lvl_d, lvl_q;
    logic              gap_last;
    logic              pend_inc, pend_dec;
    logic [PEND_W-1:0] pend_count;
    logic              pend_ovf;
    logic              pend_nonzero;

`ifdef LVL_GEN_TIMEOUT_EN
    localparam int unsigned       HOLD_W    = cnt_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q;
    logic              timeout_d, timeout_q;
`endif

    pend_ctr #(.PEND_W(PEND_W)) u_pend_ctr (
        .clk     (clk),
        .reset   (reset),
        .inc     (pend_inc),
        .dec     (pend_dec),
        .count   (pend_count),
        .ovf     (pend_ovf),
        .nonzero (pend_nonzero)
    );

    assign gap_last = (gap_cnt_q == GAP_LAST);

    // Next state, counters and queue control.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        pend_inc  = 1'b0;
        pend_dec  = 1'b0;
`ifdef LVL_GEN_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // Consumed directly; the queue is empty here.
                if (bus.pulse_sig) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                pend_inc = bus.pulse_sig;
`ifdef LVL_GEN_TIMEOUT_EN
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
                if (bus.ack) begin
                    state_d = GAP;
`ifdef LVL_GEN_TIMEOUT_EN
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = GAP;
                    timeout_d = 1'b1;
`endif
                end
            end
            GAP: begin
                if (gap_last) begin
                    // Queue has priority; a same-cycle pulse is queued behind it.
                    if (pend_nonzero) begin
                        state_d  = HOLD;
                        pend_dec = 1'b1;
                        pend_inc = bus.pulse_sig;
                    end else if (bus.pulse_sig) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    pend_inc  = bus.pulse_sig;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every state entry restarts the counters.
        if (state_d != state_q) begin
            gap_cnt_d = '0;
`ifdef LVL_GEN_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
        end

        lvl_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            lvl_q     <= 1'b0;
`ifdef LVL_GEN_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            lvl_q     <= lvl_d;
`ifdef LVL_GEN_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign bus.lvl_sig  = lvl_q;
    assign bus.pend_cnt = pend_count;
    assign bus.ovf      = pend_ovf;
`ifdef LVL_GEN_TIMEOUT_EN
    assign bus.timeout  = timeout_q;
`else
    assign bus.timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_lvl_gen.sv
// Self-checking bench for lvl_gen: a behavioural model pushes the expected
// outputs of each cycle into a queue as stimulus is applied; they are popped and
// compared one time unit after the clock edge. Directed checks cover test-plan points.
module tb_lvl_gen;
    localparam int unsigned HOLD_CYCLES = 8;
    localparam int unsigned GAP_CYCLES  = 1;
    localparam int unsigned PEND_W      = 2;
    localparam int          PEND_MAX    = (1 << PEND_W) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lvl_gen_if #(.PEND_W(PEND_W)) bus ();

    lvl_gen #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .PEND_W      (PEND_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic              lvl;
        logic [PEND_W-1:0] pend;
        logic              ovf;
        logic              tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model state: 0 idle, 1 hold, 2 gap.
    int m_state, m_hold, m_gap, m_pend;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic model_step(input logic p, input logic a);
        int   nstate;
        bit   inc;
        bit   dec;
        exp_t e;
        nstate = m_state;
        inc    = 1'b0;
        dec    = 1'b0;
        e      = '0;
        case (m_state)
            0: if (p) nstate = 1;
            1: begin
                inc = p;
                if (a) nstate = 2;
`ifdef LVL_GEN_TIMEOUT_EN
                else if (m_hold + 1 == int'(HOLD_CYCLES)) begin
                    nstate = 2;
                    e.tmo  = 1'b1;
                end
`endif
            end
            2: begin
                if (m_gap + 1 == int'(GAP_CYCLES)) begin
                    if (m_pend > 0) begin
                        nstate = 1;
                        dec    = 1'b1;
                        inc    = p;
                    end else if (p) nstate = 1;
                    else nstate = 0;
                end else begin
                    inc = p;
                end
            end
            default: ;
        endcase
        if (inc && !dec) begin
            if (m_pend == PEND_MAX) e.ovf = 1'b1;
            else m_pend++;
        end else if (dec && !inc) begin
            m_pend--;
        end
        if (nstate != m_state) begin
            m_hold = 0;
            m_gap  = 0;
        end else if (m_state == 1) m_hold++;
        else if (m_state == 2) m_gap++;
        m_state = nstate;
        e.lvl   = (nstate == 1);
        e.pend  = PEND_W'(m_pend);
        exp_q.push_back(e);
    endtask

    // One clock: drive inputs, predict, then compare after the edge.
    task automatic cycle(input logic p, input logic a, input string tag);
        exp_t e;
        bus.pulse_sig = p;
        bus.ack       = a;
        model_step(p, a);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_qempty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_lvl"},  int'(bus.lvl_sig),  int'(e.lvl));
            check_eq({tag, "_pend"}, int'(bus.pend_cnt), int'(e.pend));
            check_eq({tag, "_ovf"},  int'(bus.ovf),      int'(e.ovf));
            check_eq({tag, "_tmo"},  int'(bus.timeout),  int'(e.tmo));
        end
        bus.pulse_sig = 1'b0;
        bus.ack       = 1'b0;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_hold  = 0;
        m_gap   = 0;
        m_pend  = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        bus.pulse_sig = 1'b0;
        bus.ack       = 1'b0;
        reset         = 1'b1;
        model_reset();
        #1;
        check_eq("rst_lvl",  int'(bus.lvl_sig),  0);
        check_eq("rst_pend", int'(bus.pend_cnt), 0);
        check_eq("rst_ovf",  int'(bus.ovf),      0);
        check_eq("rst_tmo",  int'(bus.timeout),  0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Ack every level until the model is idle with an empty queue.
    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (m_state == 0 && m_pend == 0) break;
            cycle(1'b0, logic'(m_state == 1), tag);
        end
        check_eq({tag, "_idle"}, int'(bus.lvl_sig), 0);
        check_eq({tag, "_empty"}, int'(bus.pend_cnt), 0);
    endtask

    initial begin
        int hi_cnt;
        int tmo_cnt;
        int ovf_cnt;

        // Test 1: pulse at cycle 5, ack at cycle 9.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            cycle(logic'(k == 5), logic'(k == 9), "t1");
            check_eq($sformatf("t1_lvl_c%0d", k), int'(bus.lvl_sig), int'(k >= 5 && k <= 8));
            check_eq($sformatf("t1_pend_c%0d", k), int'(bus.pend_cnt), 0);
        end

        // Test 2: pulse without ack.
        hi_cnt  = 0;
        tmo_cnt = 0;
        cycle(1'b1, 1'b0, "t2_pulse");
        hi_cnt += int'(bus.lvl_sig);
`ifdef LVL_GEN_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, "t2");
            hi_cnt  += int'(bus.lvl_sig);
            tmo_cnt += int'(bus.timeout);
        end
        check_eq("t2_hi_cycles", hi_cnt, int'(HOLD_CYCLES));
        check_eq("t2_tmo_pulses", tmo_cnt, 1);
`else
        for (int i = 0; i < 99; i++) begin
            cycle(1'b0, 1'b0, "t2");
            hi_cnt  += int'(bus.lvl_sig);
            tmo_cnt += int'(bus.timeout);
        end
        check_eq("t2_hi_cycles", hi_cnt, 100);
        check_eq("t2_tmo_pulses", tmo_cnt, 0);
        cycle(1'b0, 1'b1, "t2_ack");
`endif
        drain("t2_drain");

        // Test 3: three pulses during HOLD, then acked one by one.
        cycle(1'b1, 1'b0, "t3_first");
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 1'b0, "t3_q");
            check_eq($sformatf("t3_pend_up%0d", i), int'(bus.pend_cnt), i);
        end
        for (int i = 2; i >= 0; i--) begin
            cycle(1'b0, 1'b1, "t3_ack");
            check_eq("t3_gap_low", int'(bus.lvl_sig), 0);
            cycle(1'b0, 1'b0, "t3_rise");
            check_eq("t3_rise_hi", int'(bus.lvl_sig), 1);
            check_eq($sformatf("t3_pend_dn%0d", i), int'(bus.pend_cnt), i);
        end
        drain("t3_drain");

        // Test 4: five pulses in HOLD saturate the queue.
        ovf_cnt = 0;
        cycle(1'b1, 1'b0, "t4_first");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, "t4_q");
            ovf_cnt += int'(bus.ovf);
        end
        cycle(1'b0, 1'b0, "t4_settle");
        ovf_cnt += int'(bus.ovf);
        check_eq("t4_pend_sat", int'(bus.pend_cnt), PEND_MAX);
        check_eq("t4_ovf_pulses", ovf_cnt, 2);
        drain("t4_drain");

        // Test 5a: pulse and ack in the same HOLD cycle.
        cycle(1'b1, 1'b0, "t5_first");
        cycle(1'b1, 1'b1, "t5_both");
        check_eq("t5_drop", int'(bus.lvl_sig), 0);
        check_eq("t5_pend1", int'(bus.pend_cnt), 1);
        drain("t5_drain");

`ifdef LVL_GEN_TIMEOUT_EN
        // Test 5b: ack in the cycle the timeout would fire.
        cycle(1'b1, 1'b0, "t5b_first");
        for (int i = 0; i < int'(HOLD_CYCLES) - 1; i++) cycle(1'b0, 1'b0, "t5b_hold");
        cycle(1'b0, 1'b1, "t5b_ack");
        check_eq("t5b_low", int'(bus.lvl_sig), 0);
        cycle(1'b0, 1'b0, "t5b_after");
        check_eq("t5b_no_tmo", int'(bus.timeout), 0);
        drain("t5b_drain");
`endif

        // Test 6: asynchronous reset mid-HOLD with two queued events.
        cycle(1'b1, 1'b0, "t6_first");
        cycle(1'b1, 1'b0, "t6_q1");
        cycle(1'b1, 1'b0, "t6_q2");
        check_eq("t6_pend2", int'(bus.pend_cnt), 2);
        check_eq("t6_hold", int'(bus.lvl_sig), 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_async_lvl", int'(bus.lvl_sig), 0);
        check_eq("t6_async_pend", int'(bus.pend_cnt), 0);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        cycle(1'b0, 1'b0, "t6_idle");
        check_eq("t6_idle_lvl", int'(bus.lvl_sig), 0);
        cycle(1'b1, 1'b0, "t6_again");
        check_eq("t6_again_lvl", int'(bus.lvl_sig), 1);
        drain("t6_drain");

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) == 0), "rnd");
        end
        drain("rnd_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lvl_gen.md
# lvl_gen

Pulse-to-level converter: the receiving end of single-cycle event pulses produced by `pul_gen`-style edge detectors in the USB4 logical layer. Each accepted pulse becomes a level on `lvl_sig`. The level is held until the consumer acknowledges it or, optionally, until a hold timeout expires. Pulses that arrive while a level is active or cooling down are queued in a saturating pending counter, so no event is silently merged.

## Interface
Parameters:
- `HOLD_CYCLES`, 8: maximum cycles `lvl_sig` stays high before an automatic drop (timeout build only); legal range ≥1.
- `GAP_CYCLES`, 1: minimum low cycles between two consecutive levels; legal range ≥1.
- `PEND_W`, 2: width of the pending-event counter; saturates at 2^PEND_W−1.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `pulse_sig` input 1: event pulse, sampled every cycle; each high cycle is one event.
- `ack` input 1: consumer acknowledge; ends the current level.
- `lvl_sig` output 1: level output, registered.
- `pend_cnt` output PEND_W: number of queued events not yet presented.
- `ovf` output 1: one-cycle pulse when an event is dropped because the counter is saturated.
- `timeout` output 1: one-cycle pulse when a level ends by timeout.

## Operation
- States: IDLE, HOLD, GAP.
- **IDLE** (`lvl_sig`=0): `pulse_sig`=1 → HOLD. The event is consumed directly and `pend_cnt` is unchanged. `pend_cnt`>0 cannot occur in IDLE.
- **HOLD** (`lvl_sig`=1): hold counter increments each cycle.
  - `ack`=1 → GAP.
  - Timeout build only: counter reaches HOLD_CYCLES → GAP and `timeout` pulses for one cycle.
  - `ack` and timeout in the same cycle: this counts as an ack, and `timeout` stays 0.
- **GAP** (`lvl_sig`=0): gap counter runs for GAP_CYCLES cycles. On the last gap cycle:
  - `pend_cnt`>0, or `pulse_sig`=1 that cycle → HOLD.
  - Otherwise → IDLE.
- Pending counter:
  - A pulse in HOLD or GAP, other than one consumed at the GAP exit, increments `pend_cnt`.
  - A GAP→HOLD transition decrements `pend_cnt` when the event came from the queue.
  - Decrement and increment in the same cycle leave `pend_cnt` unchanged.
  - The GAP→HOLD transition takes from the queue first; a pulse in that same cycle is queued.
  - Increment at saturation drops the event and asserts `ovf` for 1 cycle.
- `ack` in IDLE or GAP is ignored and not remembered.
- Hold and gap counters clear on every state entry.
- Hold counter width is clog2(HOLD_CYCLES+1); gap counter width is clog2(GAP_CYCLES+1).

## Timing
- Reset values: `lvl_sig`=0, `pend_cnt`=0, `ovf`=0, `timeout`=0, state IDLE, both counters 0.
- Reset while in HOLD drops `lvl_sig` immediately (asynchronously) and discards all pending events.
- Latency: pulse sampled at edge N → `lvl_sig`=1 after edge N.
- Ack: `ack` sampled at edge K → `lvl_sig`=0 after edge K.
- Timeout: `lvl_sig` is high for exactly HOLD_CYCLES cycles; `timeout` is high during the first low cycle.
- Back-to-back events: `lvl_sig` is low for exactly GAP_CYCLES cycles between two levels.
- `ovf` and `pend_cnt` are registered and update one edge after the causing pulse.

## Configuration
- Macro: `LVL_GEN_TIMEOUT_EN`.
- Defined: HOLD exits on `ack` or on timeout, as above.
- Undefined:
  - HOLD exits only on `ack`, and the level may stay high indefinitely.
  - No hold counter is built and HOLD_CYCLES is unused.
  - `timeout` is tied to 0.

## Structure
- Shared package `lvl_gen_pkg`:
  - state enum `lvl_gen_state_t` (IDLE, HOLD, GAP);
  - encoding constants;
  - function computing counter widths.
- One sub-module is natural: `pend_ctr`, a saturating up/down counter.
  - Inputs: `inc`, `dec`.
  - Outputs: `count`, `ovf`, `nonzero`.
  - Parameterised by PEND_W.
- The FSM and the hold/gap counters live in `lvl_gen`.

## Test plan
1. Reset, then a single pulse at cycle 5, `ack` at cycle 9 → `lvl_sig` high for cycles 6–9, low from cycle 10, `pend_cnt` stays 0.
2. Timeout build, HOLD_CYCLES=8, pulse with no `ack` → `lvl_sig` high for exactly 8 cycles, then one `timeout` pulse; without the macro, the level stays high for 100 cycles.
3. Three pulses during HOLD, GAP_CYCLES=1 → `pend_cnt` goes 1,2,3; after each `ack`, `lvl_sig` has one low cycle then rises again; `pend_cnt` counts down to 0.
4. PEND_W=2 with five pulses in HOLD → `pend_cnt` saturates at 3 and `ovf` pulses exactly twice.
5. Pulse and `ack` in the same HOLD cycle → level drops and `pend_cnt`=1. Separately, `ack` and timeout in the same cycle → `timeout` stays 0.
6. `reset` asserted mid-HOLD with `pend_cnt`=2 → `lvl_sig` and `pend_cnt` go to 0 without waiting for a clock edge, and the block returns to IDLE.
